// File: rtl/frame_sequencer.sv
// Overlapping-frame read sequencer over a 256-entry sample ring buffer.
// Optional frame/drop statistics counters enabled by `define FRAME_SEQ_STATS_EN.
module frame_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic       cfg_load,
  input  logic [7:0] cfg_frame_size,
  input  logic [7:0] cfg_frame_overlap,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_addr,
  output logic [7:0] rd_idx,
  output logic       rd_first,
  output logic       rd_last,
  output logic       busy,
  output logic       cfg_err,
  output logic       overrun
`ifdef FRAME_SEQ_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE, FILL, READY, READOUT
  } state_t;

  state_t     r_state, w_nxt;
  logic [7:0] r_wp, r_bp, r_ri;
  logic [7:0] r_size, r_ovl;
  logic [8:0] r_pend, w_pend_nxt;
  logic       r_cfg_err, r_overrun;
  logic [7:0] w_hop;
  logic       w_beat, w_rel, w_wr, w_drop;
  logic       w_cfg_ok, w_cfg_take;

  assign w_hop      = r_size - r_ovl;
  assign w_cfg_ok   = (cfg_frame_size >= 8'd2) &&
                      (cfg_frame_overlap < cfg_frame_size);
  assign w_cfg_take = cfg_load && (r_state == IDLE) && w_cfg_ok;

  // A release frees H slots in the same cycle, so a full buffer
  // still accepts the sample arriving with the last beat.
  always_comb begin
    w_beat     = (r_state == READOUT) && rd_ready;
    w_rel      = w_beat && (r_ri == r_size - 8'd1);
    w_wr       = sample_valid && (r_state != IDLE) &&
                 (!r_pend[8] || w_rel);
    w_drop     = sample_valid && (r_state != IDLE) &&
                 r_pend[8] && !w_rel;
    w_pend_nxt = r_pend + 9'(w_wr) -
                 (w_rel ? {1'b0, w_hop} : 9'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (enable) w_nxt = FILL;
      FILL:
        if (!enable) w_nxt = IDLE;
        else if (w_pend_nxt >= {1'b0, r_size}) w_nxt = READY;
      READY:
        if (!enable) w_nxt = IDLE;
        else if (r_pend >= {1'b0, r_size}) w_nxt = READOUT;
      READOUT:
        if (w_rel) w_nxt = enable ? READY : IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en    = w_wr;
    wr_addr  = r_wp;
    rd_valid = (r_state == READOUT);
    rd_addr  = rd_valid ? r_bp + r_ri : 8'd0;
    rd_idx   = rd_valid ? r_ri : 8'd0;
    rd_first = rd_valid && (r_ri == 8'd0);
    rd_last  = rd_valid && (r_ri == r_size - 8'd1);
    busy     = (r_state != IDLE);
    cfg_err  = r_cfg_err;
    overrun  = r_overrun;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size    <= 8'd128;
      r_ovl     <= 8'd64;
      r_cfg_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_cfg_err <= cfg_load && !w_cfg_take;
      if (w_cfg_take) begin
        r_size <= cfg_frame_size;
        r_ovl  <= cfg_frame_overlap;
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  // Pointers are cleared on the way into IDLE so they read zero there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= 8'd0;
      r_bp   <= 8'd0;
      r_ri   <= 8'd0;
      r_pend <= 9'd0;
    end else if (w_nxt == IDLE) begin
      r_wp   <= 8'd0;
      r_bp   <= 8'd0;
      r_ri   <= 8'd0;
      r_pend <= 9'd0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 8'd1;
      if (w_rel) r_bp <= r_bp + w_hop;
      r_pend <= w_pend_nxt;
      if (r_state != READOUT) r_ri <= 8'd0;
      else if (w_beat)        r_ri <= w_rel ? 8'd0 : r_ri + 8'd1;
    end
  end

`ifdef FRAME_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      if (w_rel) frame_cnt <= frame_cnt + 16'd1;
      if (w_drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
